// File: rtl/bus_transfer_ctrl.sv
// Bus-master sequencer: queues (src,dst) transfer requests and drives
// OE / bus value / WE in a fixed DRIVE -> WRITE two-phase sequence.
module bus_transfer_ctrl #(
  parameter int DATA_W = 8,
  parameter int NSRC   = 4,
  parameter int NDST   = 4
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   req_valid,
  input  logic [1:0]             req_src,
  input  logic [1:0]             req_dst,
  output logic                   req_ready,
  input  logic [NSRC*DATA_W-1:0] src_data,
  output logic [NSRC-1:0]        oe,
  output logic [NDST-1:0]        we,
  output logic [DATA_W-1:0]      bus_out,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    WRITE
  } state_t;

  state_t state_q, state_d;

  logic [1:0][3:0]    fifo_q, fifo_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [1:0]         cur_src_q, cur_src_d;
  logic [1:0]         cur_dst_q, cur_dst_d;
  logic [NSRC-1:0]    oe_q, oe_d;
  logic [NDST-1:0]    we_q, we_d;
  logic [DATA_W-1:0]  bus_q, bus_d;
  logic               done_q, done_d;

  logic               push;
  logic               pop;
  logic [3:0]         head;

  assign req_ready = (cnt_q != 2'd2);
  assign push      = req_valid && req_ready;
  assign head      = fifo_q[rd_ptr_q];
  assign busy      = (state_q != IDLE) || (cnt_q != 2'd0);

  assign oe      = oe_q;
  assign we      = we_q;
  assign bus_out = bus_q;
  assign done    = done_q;

  always_comb begin
    state_d   = state_q;
    cur_src_d = cur_src_q;
    cur_dst_d = cur_dst_q;
    oe_d      = '0;
    we_d      = '0;
    bus_d     = bus_q;
    done_d    = 1'b0;
    pop       = 1'b0;
    unique case (state_q)
      IDLE, WRITE: begin
        // Next transfer starts straight from WRITE for back-to-back rate.
        if (cnt_q != 2'd0) begin
          pop       = 1'b1;
          cur_src_d = head[3:2];
          cur_dst_d = head[1:0];
          oe_d[head[3:2]] = 1'b1;
          state_d   = DRIVE;
        end else begin
          state_d = IDLE;
        end
      end
      DRIVE: begin
        bus_d = src_data[cur_src_q*DATA_W +: DATA_W];
        oe_d[cur_src_q] = 1'b1;
        we_d[cur_dst_q] = 1'b1;
        done_d  = 1'b1;
        state_d = WRITE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fifo_d = fifo_q;
    if (push) begin
      fifo_d[wr_ptr_q] = {req_src, req_dst};
    end
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    cnt_d    = cnt_q + 2'(push) - 2'(pop);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      fifo_q    <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
      cur_src_q <= 2'd0;
      cur_dst_q <= 2'd0;
      oe_q      <= '0;
      we_q      <= '0;
      bus_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      fifo_q    <= fifo_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      cur_src_q <= cur_src_d;
      cur_dst_q <= cur_dst_d;
      oe_q      <= oe_d;
      we_q      <= we_d;
      bus_q     <= bus_d;
      done_q    <= done_d;
    end
  end

endmodule
